// File: rtl/udiv8_seq.sv
//------------------------------------------------------------------------------
// Module   : udiv8_seq
// Brief    : Sequential unsigned restoring divider, one quotient bit per clock.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module udiv8_seq #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [WIDTH-1:0] DIVIDEND,
    input  logic [WIDTH-1:0] DIVISOR,
    output logic             BUSY,
    output logic             VALID,
    output logic [WIDTH-1:0] QUOTIENT,
    output logic [WIDTH-1:0] REMAINDER,
    output logic             DIV_BY_ZERO
);

    localparam int c_CNT_W = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_dvd;
    logic [WIDTH-1:0]   r_dvs;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_rmd;
    logic               r_dbz;
    logic               r_valid;

    logic               w_accept;
    logic               w_last;
    logic [WIDTH:0]     w_rp;
    logic [WIDTH+1:0]   w_sum;
    logic               w_carry;
    logic [WIDTH-1:0]   w_rem_nxt;
    logic [WIDTH-1:0]   w_dvd_nxt;
    logic               w_unused_sum_bit;

    assign w_accept = START && ((r_state == c_IDLE) || (r_state == c_DONE));
    assign w_last   = (r_state == c_RUN) && (r_cnt == c_LAST);

    // r' >= divisor is the carry-out of r' + ~{0,divisor} + 1 at WIDTH+1 bits.
    assign w_rp      = {r_rem, r_dvd[WIDTH-1]};
    assign w_sum     = {1'b0, w_rp} + {1'b0, ~{1'b0, r_dvs}} + {{(WIDTH+1){1'b0}}, 1'b1};
    assign w_carry   = w_sum[WIDTH+1];
    assign w_rem_nxt = w_carry ? w_sum[WIDTH-1:0] : w_rp[WIDTH-1:0];
    // Dividend bits shift out the top while quotient bits shift in below.
    assign w_dvd_nxt = {r_dvd[WIDTH-2:0], w_carry};
    assign w_unused_sum_bit = w_sum[WIDTH];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (START) begin
                    w_next_state = (DIVISOR == '0) ? c_DONE : c_RUN;
                end
            end
            c_RUN: begin
                if (w_last) begin
                    w_next_state = c_DONE;
                end
            end
            c_DONE: begin
                if (START) begin
                    w_next_state = (DIVISOR == '0) ? c_DONE : c_RUN;
                end else begin
                    w_next_state = c_IDLE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_cnt   <= '0;
            r_rem   <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_quo   <= '0;
            r_rmd   <= '0;
            r_dbz   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_accept) begin
                r_dvd <= DIVIDEND;
                r_dvs <= DIVISOR;
                r_rem <= '0;
                r_cnt <= '0;
                if (DIVISOR == '0) begin
                    r_quo   <= '1;
                    r_rmd   <= DIVIDEND;
                    r_dbz   <= 1'b1;
                    r_valid <= 1'b1;
                end
            end else if (r_state == c_RUN) begin
                r_rem <= w_rem_nxt;
                r_dvd <= w_dvd_nxt;
                r_cnt <= r_cnt + c_CNT_W'(1);
                if (w_last) begin
                    r_quo   <= w_dvd_nxt;
                    r_rmd   <= w_rem_nxt;
                    r_dbz   <= 1'b0;
                    r_valid <= 1'b1;
                end
            end
        end
    end

    assign BUSY        = (r_state == c_RUN);
    assign VALID       = r_valid;
    assign QUOTIENT    = r_quo;
    assign REMAINDER   = r_rmd;
    assign DIV_BY_ZERO = r_dbz;

endmodule

`default_nettype wire
